// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//
// Multi-cycle control sequencer for the 9-bit-instruction CPU. It owns the
// program counter, walks each instruction through FETCH, DECODE, EXEC, MEM
// and WB, and turns the decoder's write/read requests into single-state
// enables. Program completion is reported to the host via START/DONE.
//
// Parameters:
//   PC_W         program counter width (PC arithmetic wraps modulo 2^PC_W)
//   MEM_TIMEOUT  cycles allowed waiting on MEM_READY before flagging ERR
//
// Ports:
//   CLK, RESET_N         clock (rising edge), async active-low reset
//   START, START_ADDR    host start level and first instruction address
//   DEC_*                decoder outputs for the instruction held in IR
//   BR_TAKEN, BR_TARGET  branch outcome and destination, valid in EXEC
//   MEM_READY            data memory completion, sampled only in MEM
//   PC                   program counter / ROM address
//   IR_LOAD              latch ROM word into IR (FETCH)
//   REG_WE               register file write enable (WB)
//   MEM_RE, MEM_WE       data memory strobes (MEM)
//   DONE, ERR            program finished / memory timeout
//   INSTR_COUNT          retired instruction count, saturating
//   STATE                encoded current state

module cpu_sequencer #(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [PC_W-1:0] START_ADDR,
  input  logic            DEC_REG_WRITE,
  input  logic            DEC_MEM_READ,
  input  logic            DEC_MEM_WRITE,
  input  logic            DEC_BRANCH,
  input  logic            DEC_HALT,
  input  logic            BR_TAKEN,
  input  logic [PC_W-1:0] BR_TARGET,
  input  logic            MEM_READY,
  output logic [PC_W-1:0] PC,
  output logic            IR_LOAD,
  output logic            REG_WE,
  output logic            MEM_RE,
  output logic            MEM_WE,
  output logic            DONE,
  output logic            ERR,
  output logic [15:0]     INSTR_COUNT,
  output logic [2:0]      STATE
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         count_q, count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                armed_q, armed_d;
  logic                err_q, err_d;
  // DEC_HALT is acted on directly in DECODE, so only four decoder flags
  // need to survive into EXEC/MEM/WB.
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                branch_q, branch_d;

  logic                retire;
  logic [PC_W-1:0]     retire_pc;
  logic [15:0]         count_inc;

  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    wait_d      = wait_q;
    armed_d     = armed_q;
    err_d       = err_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    retire      = 1'b0;
    retire_pc   = pc_q + PC_W'(1);

    case (state_q)
      S_IDLE: begin
        // The program starts on the falling edge of START, not while it is held.
        if (START) begin
          pc_d    = START_ADDR;
          armed_d = 1'b1;
          count_d = '0;
        end else if (armed_q) begin
          state_d = S_FETCH;
          armed_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        reg_write_d = DEC_REG_WRITE;
        mem_read_d  = DEC_MEM_READ;
        mem_write_d = DEC_MEM_WRITE;
        branch_d    = DEC_BRANCH;
        if (DEC_HALT) begin
          state_d = S_HALTED;
          count_d = count_inc;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mem_read_q || mem_write_q) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (reg_write_q) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
          if (branch_q && BR_TAKEN) retire_pc = BR_TARGET;
        end
      end
      S_MEM: begin
        if (MEM_READY) begin
          if (mem_read_q) state_d = S_WB;
          else            retire  = 1'b1;
        end else if (wait_q == WAIT_LIMIT) begin
          // Timeout abandons the instruction: no retire, PC untouched.
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: retire = 1'b1;
      S_HALTED: begin
        // Restart performs the IDLE start actions in the same cycle.
        if (START) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          pc_d    = START_ADDR;
          armed_d = 1'b1;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      pc_d    = retire_pc;
      count_d = count_inc;
      state_d = S_FETCH;
    end
  end

  // Moore outputs: decoded only from registered state and latched flags.
  assign PC          = pc_q;
  assign IR_LOAD     = (state_q == S_FETCH);
  assign REG_WE      = (state_q == S_WB);
  assign MEM_RE      = (state_q == S_MEM) && mem_read_q;
  assign MEM_WE      = (state_q == S_MEM) && mem_write_q;
  assign DONE        = (state_q == S_HALTED);
  assign ERR         = err_q;
  assign INSTR_COUNT = count_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//
// Directed testbench for cpu_sequencer. Each scenario task drives the host,
// decoder, branch and memory inputs and compares outputs against
// hand-computed values.

module tb_cpu_sequencer;

  localparam int PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            dec_rw, dec_mr, dec_mw, dec_br, dec_ht;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            mem_ready;

  logic [PC_W-1:0] PC;
  logic            IR_LOAD, REG_WE, MEM_RE, MEM_WE, DONE, ERR;
  logic [15:0]     INSTR_COUNT;
  logic [2:0]      STATE;
  logic [34:0]     outs;

  int total;
  int bad;

  cpu_sequencer #(.PC_W(PC_W), .MEM_TIMEOUT(15)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .START(start),
    .START_ADDR(start_addr),
    .DEC_REG_WRITE(dec_rw),
    .DEC_MEM_READ(dec_mr),
    .DEC_MEM_WRITE(dec_mw),
    .DEC_BRANCH(dec_br),
    .DEC_HALT(dec_ht),
    .BR_TAKEN(br_taken),
    .BR_TARGET(br_target),
    .MEM_READY(mem_ready),
    .PC(PC),
    .IR_LOAD(IR_LOAD),
    .REG_WE(REG_WE),
    .MEM_RE(MEM_RE),
    .MEM_WE(MEM_WE),
    .DONE(DONE),
    .ERR(ERR),
    .INSTR_COUNT(INSTR_COUNT),
    .STATE(STATE)
  );

  assign outs = {PC, IR_LOAD, REG_WE, MEM_RE, MEM_WE, DONE, ERR, INSTR_COUNT, STATE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic mr, input logic mw,
                         input logic br, input logic ht);
    dec_rw = rw; dec_mr = mr; dec_mw = mw; dec_br = br; dec_ht = ht;
  endtask

  task automatic apply_reset();
    start = 0; start_addr = '0; br_taken = 0; br_target = '0; mem_ready = 0;
    set_dec(0, 0, 0, 0, 0);
    rst_n = 0;
    #3;
    rst_n = 1;
  endtask

  // Hold START three cycles, drop it; returns in the first FETCH cycle.
  task automatic launch(input logic [PC_W-1:0] addr);
    start = 1; start_addr = addr;
    repeat (3) tick();
    start = 0;
    tick();
  endtask

  // Steps one instruction from FETCH until the next FETCH or HALTED,
  // raising MEM_READY on MEM cycle number waits+1.
  task automatic run_instr(input int waits, output int cycles, output int re_n,
                           output int we_n, output int rwe_n);
    int mem_cycles;
    cycles = 0; re_n = 0; we_n = 0; rwe_n = 0; mem_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (MEM_RE) re_n++;
      if (MEM_WE) we_n++;
      if (REG_WE) rwe_n++;
      if (STATE == 3'd4) begin
        mem_ready = (mem_cycles == waits);
        mem_cycles++;
      end else begin
        mem_ready = 0;
      end
      tick();
      cycles++;
      if (STATE == 3'd1 || STATE == 3'd6) break;
    end
    mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; start_addr = '0; br_taken = 0; br_target = '0;
    mem_ready = 0; set_dec(0, 0, 0, 0, 0);
    #2;
    total++;
    if (outs !== 35'd0) begin bad++; $display("FAIL reset_outs got %h want 0", outs); end
    tick();
    total++;
    if (outs !== 35'd0) begin bad++; $display("FAIL reset_held got %h want 0", outs); end
    rst_n = 1;
  endtask

  task automatic test_add();
    apply_reset();
    launch(10'h010);
    total++;
    if (STATE !== 3'd1 || PC !== 10'h010 || IR_LOAD !== 1'b1) begin
      bad++; $display("FAIL add_fetch got state=%0d pc=%h irl=%b want 1 010 1", STATE, PC, IR_LOAD);
    end
    set_dec(1, 0, 0, 0, 0);
    tick();
    total++;
    if (STATE !== 3'd2 || IR_LOAD !== 1'b0) begin
      bad++; $display("FAIL add_decode got state=%0d irl=%b want 2 0", STATE, IR_LOAD);
    end
    tick();
    total++;
    if (STATE !== 3'd3 || REG_WE !== 1'b0) begin
      bad++; $display("FAIL add_exec got state=%0d we=%b want 3 0", STATE, REG_WE);
    end
    tick();
    total++;
    if (STATE !== 3'd5 || REG_WE !== 1'b1) begin
      bad++; $display("FAIL add_wb got state=%0d we=%b want 5 1", STATE, REG_WE);
    end
    tick();
    total++;
    if (STATE !== 3'd1 || REG_WE !== 1'b0) begin
      bad++; $display("FAIL add_next got state=%0d we=%b want 1 0", STATE, REG_WE);
    end
    total++;
    if (PC !== 10'h011) begin bad++; $display("FAIL add_pc got %h want 011", PC); end
    total++;
    if (INSTR_COUNT !== 16'd1) begin bad++; $display("FAIL add_count got %0d want 1", INSTR_COUNT); end
  endtask

  task automatic test_mem();
    int cyc, re_n, we_n, rwe_n;
    apply_reset();
    launch(10'h100);
    set_dec(1, 1, 0, 0, 0);
    run_instr(3, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 8 || re_n !== 4 || we_n !== 0 || rwe_n !== 1) begin
      bad++; $display("FAIL lw_timing got cyc=%0d re=%0d we=%0d rwe=%0d want 8 4 0 1", cyc, re_n, we_n, rwe_n);
    end
    total++;
    if (PC !== 10'h101 || INSTR_COUNT !== 16'd1) begin
      bad++; $display("FAIL lw_retire got pc=%h cnt=%0d want 101 1", PC, INSTR_COUNT);
    end
    set_dec(0, 0, 1, 0, 0);
    run_instr(3, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 7 || re_n !== 0 || we_n !== 4 || rwe_n !== 0) begin
      bad++; $display("FAIL sw_timing got cyc=%0d re=%0d we=%0d rwe=%0d want 7 0 4 0", cyc, re_n, we_n, rwe_n);
    end
    total++;
    if (PC !== 10'h102 || INSTR_COUNT !== 16'd2) begin
      bad++; $display("FAIL sw_retire got pc=%h cnt=%0d want 102 2", PC, INSTR_COUNT);
    end
    set_dec(1, 1, 0, 0, 0);
    run_instr(0, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 5 || re_n !== 1) begin
      bad++; $display("FAIL lw_nowait got cyc=%0d re=%0d want 5 1", cyc, re_n);
    end
  endtask

  task automatic test_branch();
    int cyc, re_n, we_n, rwe_n;
    apply_reset();
    launch(10'h020);
    set_dec(0, 0, 0, 1, 0);
    br_taken = 1; br_target = 10'h005;
    run_instr(0, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 3 || PC !== 10'h005) begin
      bad++; $display("FAIL br_taken got cyc=%0d pc=%h want 3 005", cyc, PC);
    end
    apply_reset();
    launch(10'h020);
    set_dec(0, 0, 0, 1, 0);
    br_taken = 0; br_target = 10'h005;
    run_instr(0, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 3 || PC !== 10'h021 || rwe_n !== 0) begin
      bad++; $display("FAIL br_not_taken got cyc=%0d pc=%h rwe=%0d want 3 021 0", cyc, PC, rwe_n);
    end
  endtask

  task automatic test_halt();
    int cyc, re_n, we_n, rwe_n;
    apply_reset();
    launch(10'h040);
    set_dec(1, 0, 0, 0, 0);
    run_instr(0, cyc, re_n, we_n, rwe_n);
    set_dec(0, 0, 0, 1, 0);
    br_taken = 0;
    run_instr(0, cyc, re_n, we_n, rwe_n);
    set_dec(0, 0, 0, 0, 1);
    run_instr(0, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 2 || STATE !== 3'd6 || DONE !== 1'b1) begin
      bad++; $display("FAIL halt_enter got cyc=%0d state=%0d done=%b want 2 6 1", cyc, STATE, DONE);
    end
    total++;
    if (INSTR_COUNT !== 16'd3 || PC !== 10'h042) begin
      bad++; $display("FAIL halt_count got cnt=%0d pc=%h want 3 042", INSTR_COUNT, PC);
    end
    repeat (3) tick();
    total++;
    if (DONE !== 1'b1 || PC !== 10'h042 || ERR !== 1'b0) begin
      bad++; $display("FAIL halt_hold got done=%b pc=%h err=%b want 1 042 0", DONE, PC, ERR);
    end
    start = 1; start_addr = 10'h123;
    tick();
    total++;
    if (STATE !== 3'd0 || DONE !== 1'b0 || INSTR_COUNT !== 16'd0 || PC !== 10'h123) begin
      bad++; $display("FAIL halt_restart got state=%0d done=%b cnt=%0d pc=%h want 0 0 0 123", STATE, DONE, INSTR_COUNT, PC);
    end
    start = 0;
    tick();
    total++;
    if (STATE !== 3'd1) begin bad++; $display("FAIL restart_fetch got %0d want 1", STATE); end
  endtask

  task automatic test_timeout();
    int cyc, re_n, we_n, rwe_n;
    apply_reset();
    launch(10'h050);
    set_dec(0, 0, 1, 0, 0);
    run_instr(99, cyc, re_n, we_n, rwe_n);
    total++;
    if (cyc !== 19 || we_n !== 16) begin
      bad++; $display("FAIL timeout_len got cyc=%0d we=%0d want 19 16", cyc, we_n);
    end
    total++;
    if (ERR !== 1'b1 || DONE !== 1'b1 || STATE !== 3'd6) begin
      bad++; $display("FAIL timeout_flags got err=%b done=%b state=%0d want 1 1 6", ERR, DONE, STATE);
    end
    total++;
    if (PC !== 10'h050 || INSTR_COUNT !== 16'd0) begin
      bad++; $display("FAIL timeout_pc got pc=%h cnt=%0d want 050 0", PC, INSTR_COUNT);
    end
    start = 1;
    tick();
    start = 0;
    total++;
    if (ERR !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got err=%b done=%b want 0 0", ERR, DONE);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    launch(10'h060);
    set_dec(1, 1, 0, 0, 0);
    repeat (3) tick();
    total++;
    if (STATE !== 3'd4 || MEM_RE !== 1'b1) begin
      bad++; $display("FAIL mid_mem_setup got state=%0d re=%b want 4 1", STATE, MEM_RE);
    end
    rst_n = 0;
    #2;
    total++;
    if (outs !== 35'd0) begin bad++; $display("FAIL reset_in_mem got %h want 0", outs); end
    rst_n = 1;
    apply_reset();
    launch(10'h070);
    set_dec(1, 0, 0, 0, 0);
    repeat (3) tick();
    total++;
    if (STATE !== 3'd5 || REG_WE !== 1'b1) begin
      bad++; $display("FAIL mid_wb_setup got state=%0d we=%b want 5 1", STATE, REG_WE);
    end
    rst_n = 0;
    #2;
    total++;
    if (outs !== 35'd0) begin bad++; $display("FAIL reset_in_wb got %h want 0", outs); end
    rst_n = 1;
  endtask

  task automatic test_wrap();
    int cyc, re_n, we_n, rwe_n;
    apply_reset();
    launch(10'h3FF);
    set_dec(1, 0, 0, 0, 0);
    run_instr(0, cyc, re_n, we_n, rwe_n);
    total++;
    if (PC !== 10'h000 || cyc !== 4) begin
      bad++; $display("FAIL pc_wrap got pc=%h cyc=%0d want 000 4", PC, cyc);
    end
  endtask

  // Decoder changes after DECODE and START while running must be ignored.
  task automatic test_back_to_back();
    apply_reset();
    launch(10'h200);
    set_dec(1, 0, 0, 0, 0);
    tick();
    tick();
    set_dec(0, 1, 1, 1, 1);
    start = 1; start_addr = 10'h0AA;
    br_taken = 1; br_target = 10'h0BB;
    tick();
    total++;
    if (STATE !== 3'd5 || MEM_RE !== 1'b0 || MEM_WE !== 1'b0) begin
      bad++; $display("FAIL latch_wb got state=%0d re=%b we=%b want 5 0 0", STATE, MEM_RE, MEM_WE);
    end
    tick();
    start = 0;
    total++;
    if (STATE !== 3'd1 || PC !== 10'h201 || INSTR_COUNT !== 16'd1) begin
      bad++; $display("FAIL start_ignored got state=%0d pc=%h cnt=%0d want 1 201 1", STATE, PC, INSTR_COUNT);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add();
    test_mem();
    test_branch();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
